// File: rtl/count_pkg.sv
// Shared constants and helpers for the free-running counter and its consumers.
package count_pkg;

    localparam int SEG_W = 16;
    localparam int CNT_W = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    // Number of SEG_W-bit incrementer slices needed to cover a counter of the given width.
    function automatic int nsegs(input int width);
        return (width + SEG_W - 1) / SEG_W;
    endfunction

endpackage

// File: rtl/count_inc_seg.sv
// One slice of the segmented incrementer: adds a carry-in to a W-bit slice of the count.
module count_inc_seg
    import count_pkg::*;
#(
    parameter int W = SEG_W
) (
    input  logic [W-1:0] i_a,
    input  logic         i_ci,
    output logic [W-1:0] o_sum,
    output logic         o_co
);

    assign {o_co, o_sum} = {1'b0, i_a} + {{W{1'b0}}, i_ci};

endmodule

// File: rtl/count.sv
// Free-running binary up-counter with async-assert / sync-release reset and a
// carry-chained incrementer built from SEG_W-bit slices.
module count
    import count_pkg::*;
#(
    parameter int               WIDTH   = CNT_W,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [WIDTH-1:0] cnt
);

    localparam int NSEG = nsegs(WIDTH);

    logic [1:0]       r_rst_sync;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_next;
    logic [NSEG:0]    w_carry;
    logic             w_run;
    logic             w_unused_carry;

    // Reset asserts asynchronously but releases two edges later, so the first
    // counting edge never races against rstn rising.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run      = r_rst_sync[1];
    assign w_carry[0] = 1'b1;

    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        localparam int LO = g * SEG_W;
        localparam int SW = ((WIDTH - LO) < SEG_W) ? (WIDTH - LO) : SEG_W;

        count_inc_seg #(
            .W(SW)
        ) u_seg (
            .i_a  (r_cnt[LO +: SW]),
            .i_ci (w_carry[g]),
            .o_sum(w_next[LO +: SW]),
            .o_co (w_carry[g+1])
        );
    end

    // Carry out of the top bit is dropped: the count wraps modulo 2^WIDTH.
    assign w_unused_carry = w_carry[NSEG];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= RST_VAL;
        end else if (w_run) begin
            r_cnt <= w_next;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: tb/tb_count.sv
// Bench for count: four builds sharing clock and reset, checked against an
// edges-since-release model plus literal expectations.
module tb_count;

    localparam logic [31:0] RV_A = 32'h0000_0000;
    localparam logic [31:0] RV_W = 32'hFFFF_FFFE;
    localparam logic [31:0] RV_S = 32'h0000_FFFF;
    localparam logic [19:0] RV_N = 20'hF_FFFD;
    localparam int unsigned SYNC_EDGES = 2;

    logic        clk;
    logic        rstn;
    logic [31:0] cnt_a;
    logic [31:0] cnt_w;
    logic [31:0] cnt_s;
    logic [19:0] cnt_n;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned e_edges  = 0;
    bit          model_on = 1'b0;

    count u_dut_a (.clk(clk), .rstn(rstn), .cnt(cnt_a));
    count #(.WIDTH(32), .RST_VAL(RV_W)) u_dut_w (.clk(clk), .rstn(rstn), .cnt(cnt_w));
    count #(.WIDTH(32), .RST_VAL(RV_S)) u_dut_s (.clk(clk), .rstn(rstn), .cnt(cnt_s));
    count #(.WIDTH(20), .RST_VAL(RV_N)) u_dut_n (.clk(clk), .rstn(rstn), .cnt(cnt_n));

    // Clock: period 10, first rising edge at t=10.
    initial begin
        clk = 1'b0;
        #10;
        forever begin
            clk = 1'b1;
            #5;
            clk = 1'b0;
            #5;
        end
    end

    // Model: value = RST_VAL + (rising edges since release - synchroniser edges), mod 2^W.
    always @(posedge clk) if (rstn === 1'b1) e_edges++;
    always @(negedge rstn) e_edges = 0;

    function automatic logic [63:0] exp_val(input logic [63:0] rv, input int w);
        logic [63:0] n;
        logic [63:0] mask;
        n    = (e_edges > SYNC_EDGES) ? 64'(e_edges - SYNC_EDGES) : 64'd0;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (rv + n) & mask;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            check("model_a", 64'(cnt_a), exp_val(64'(RV_A), 32));
            check("model_w", 64'(cnt_w), exp_val(64'(RV_W), 32));
            check("model_s", 64'(cnt_s), exp_val(64'(RV_S), 32));
            check("model_n", 64'(cnt_n), exp_val(64'(RV_N), 20));
        end
    end

    // Offsets from a rising edge that keep rstn changes and the +1 probe off both clock edges.
    function automatic int rand_off();
        int r;
        r = $urandom_range(0, 5);
        return (r < 3) ? (r + 1) : (r + 3);
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_a"}, 64'(cnt_a), 64'(RV_A));
        check({tag, "_w"}, 64'(cnt_w), 64'(RV_W));
        check({tag, "_s"}, 64'(cnt_s), 64'(RV_S));
        check({tag, "_n"}, 64'(cnt_n), 64'(RV_N));
    endtask

    task automatic assert_reset_async();
        int d;
        @(posedge clk);
        d = rand_off();
        #(d);
        rstn = 1'b0;
        #1;
        check_reset_vals("assert_now");
    endtask

    task automatic release_reset();
        int d;
        @(posedge clk);
        d = rand_off();
        #(d);
        rstn = 1'b1;
    endtask

    task automatic run_edges(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int k;
        rstn = 1'b1;
        #1;
        rstn = 1'b0;
        #1;
        check_reset_vals("por");
        model_on = 1'b1;

        // Clean release between edges; two synchroniser edges, then counting.
        run_edges(2);
        #3;
        rstn = 1'b1;
        run_edges(3);
        #1;
        check("wrap_e1", 64'(cnt_w), 64'h0000_0000_FFFF_FFFF);
        check("segc_e1", 64'(cnt_s), 64'h0000_0000_0001_0000);
        check("narrow_e1", 64'(cnt_n), 64'h0000_0000_000F_FFFE);
        run_edges(1);
        #1;
        check("wrap_e2", 64'(cnt_w), 64'h0);
        check("narrow_e2", 64'(cnt_n), 64'h0000_0000_000F_FFFF);
        run_edges(1);
        #1;
        check("wrap_e3", 64'(cnt_w), 64'h1);
        check("narrow_e3", 64'(cnt_n), 64'h0);
        run_edges(7);
        #1;
        check("count_10", 64'(cnt_a), 64'd10);

        // Asynchronous pulse mid-count, one period long.
        #2;
        rstn = 1'b0;
        #1;
        check("pulse_now", 64'(cnt_a), 64'd0);
        #9;
        rstn = 1'b1;
        run_edges(7);
        #1;
        check("pulse_after5", 64'(cnt_a), 64'd5);

        // Reset held for five periods with the clock running.
        assert_reset_async();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("held", 64'(cnt_a), 64'd0);
        end
        release_reset();
        run_edges(5);
        #1;
        check("held_after3", 64'(cnt_a), 64'd3);

        // Random count lengths, pulse widths and pulse placement.
        for (int it = 0; it < 25; it++) begin
            run_edges($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #2;
                rstn = 1'b0;
                #1;
                check_reset_vals("short_pulse");
                #1;
                rstn = 1'b1;
            end else begin
                assert_reset_async();
                run_edges($urandom_range(0, 3));
                release_reset();
            end
        end
        run_edges(40);

        // Release coincident with a rising edge: that edge must not count.
        assert_reset_async();
        run_edges(2);
        model_on = 1'b0;
        @(posedge clk);
        rstn = 1'b1;
        #1;
        check("coinc_e0", 64'(cnt_a), 64'd0);
        @(posedge clk);
        #1;
        check("coinc_e1", 64'(cnt_a), 64'd0);
        k = 0;
        while (cnt_a == 32'd0 && k < 3) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("coinc_first", 64'(cnt_a), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check("coinc_run", 64'(cnt_a), 64'(1 + i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
